led_status_ctrl: RTL

//  Parametrised N-channel status-LED driver for the board-level top of the

---
 rtl/led_status_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/led_status_ctrl.sv
`timescale 1ns/1ps
// led_status_ctrl
//   N-channel status-LED driver. Each channel selects one of four display
//   modes (level, activity pulse-stretch, blink, invert) so that short events
//   such as UART bytes or authentication strobes remain visible on a board LED.
//
//   Optional feature: define LED_PWM_EN to add a global PWM brightness control.
//   Without it, brightness is ignored and no PWM logic is built.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   ch_in      in   [NUM_CH]   status inputs, may be asynchronous to clk
//   ch_mode    in   [2*NUM_CH] mode of channel i at [2i+1:2i]
//                   00 level, 01 stretch, 10 blink, 11 invert
//   brightness in   [PWM_BITS] global duty (LED_PWM_EN only)
//   led        out  [NUM_CH]   registered LED pin drive (inverted if ACTIVE_LOW)

module led_status_ctrl #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned BLINK_TICKS   = 250,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned PWM_BITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     ch_in,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [NUM_CH-1:0]     led
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned SW = $clog2(STRETCH_TICKS + 1);

  typedef enum logic [1:0] {
    ARM_WAIT0,
    ARM_WAIT1,
    ARM_WAIT2,
    ARM_DONE
  } arm_state_e;

  arm_state_e arm_state_q, arm_state_d;

  logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;
  logic [CW-1:0]     presc_q, presc_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [SW-1:0]     stretch_q [NUM_CH];
  logic [SW-1:0]     stretch_d [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;

  logic              tick;
  logic              armed;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] lit;

  assign tick     = (presc_q == CW'(TICK_DIV - 1));
  assign armed    = (arm_state_q == ARM_DONE);
  assign edge_det = sync2_q ^ prev_q;
  assign led      = led_q;

  // Arming sequence: edges seen in the first cycles after reset release
  // come from inputs that were already high (idle-high rx) and are ignored.
  always_comb begin
    arm_state_d = arm_state_q;
    unique case (arm_state_q)
      ARM_WAIT0: arm_state_d = ARM_WAIT1;
      ARM_WAIT1: arm_state_d = ARM_WAIT2;
      ARM_WAIT2: arm_state_d = ARM_DONE;
      ARM_DONE:  arm_state_d = ARM_DONE;
      default:   arm_state_d = ARM_WAIT0;
    endcase
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + CW'(1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    stretch_d = stretch_q;
    raw       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // A fresh edge reloads even when a tick lands in the same cycle.
      if (armed && edge_det[i]) begin
        stretch_d[i] = SW'(STRETCH_TICKS);
      end else if (tick && (stretch_q[i] != '0)) begin
        stretch_d[i] = stretch_q[i] - SW'(1);
      end
      unique case (ch_mode[2*i +: 2])
        2'b00:   raw[i] = sync2_q[i];
        2'b01:   raw[i] = (stretch_q[i] != '0);
        2'b10:   raw[i] = sync2_q[i] & phase_q;
        default: raw[i] = ~sync2_q[i];
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_q;
  logic                duty_on;

  // Full-scale brightness bypasses the comparator so the LED is never dark.
  assign duty_on = (brightness == '1) || (pwm_q < brightness);
  assign lit     = raw & {NUM_CH{duty_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_BITS'(1);
    end
  end
`else
  logic brightness_unused;

  assign brightness_unused = ^brightness;
  assign lit               = raw;
`endif

  assign led_d = lit ^ {NUM_CH{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_state_q <= ARM_WAIT0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= {NUM_CH{ACTIVE_LOW}};
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        stretch_q[i] <= '0;
      end
    end else begin
      arm_state_q <= arm_state_d;
      sync1_q     <= ch_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        stretch_q[i] <= stretch_d[i];
      end
    end
  end

endmodule
